// File: rtl/logic_unit_pkg.sv
// Shared opcode constants and FSM state encoding
// for the arbitrated logic unit.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational W-bit two-operand bitwise unit,
// shared by all requesters of the arbiter.
module logic_unit #(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    import logic_unit_pkg::*;

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter for four requesters sharing
// one logic unit; one operation in flight at a time.
module logic_unit_arbiter #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [2*N-1:0] req_op,
    input  logic [W*N-1:0] req_a,
    input  logic [W*N-1:0] req_b,
    output logic           rsp_valid,
    output logic [1:0]     rsp_id,
    output logic [W-1:0]   rsp_data,
    input  logic           rsp_ready
);
    import logic_unit_pkg::*;

    state_t       state_q, state_d;
    logic [1:0]   rr_ptr_q;
    logic [1:0]   op_q;
    logic [W-1:0] a_q, b_q;
    logic [1:0]   id_q;
    logic [W-1:0] rsp_data_q;
    logic [W-1:0] lu_y;

    logic [N-1:0] grant;
    logic [1:0]   gidx;
    logic [1:0]   cand;
    logic         found;
    logic         accept;

    // Search upward from rr_ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        grant = '0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    assign accept = (state_q == S_IDLE) && found;

    // rst_n gate keeps the grant low while reset is held.
    assign req_ready = (state_q == S_IDLE && rst_n) ? grant : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= req_op[{gidx, 1'b0} +: 2];
                a_q      <= req_a[W*gidx +: W];
                b_q      <= req_b[W*gidx +: W];
                id_q     <= gidx;
                rr_ptr_q <= gidx + 2'd1;
            end
            if (state_q == S_EXEC) rsp_data_q <= lu_y;
        end
    end

    logic_unit #(.W(W)) u_lu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (lu_y)
    );

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and random checks of logic_unit_arbiter
// against a transaction-level reference model.
module tb_logic_unit_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;

    int checks = 0;
    int errors = 0;

    logic_unit_arbiter #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one transaction in flight, counted in edges since accept.
    bit         m_busy;
    int         m_age;
    int         m_ptr;
    int         m_id;
    logic [W-1:0] m_res;
    logic [W-1:0] m_data;

    int         cycle = 0;
    logic [3:0] last_ready;
    logic [3:0] gq[$];
    int         tq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_grant(input logic [3:0] v,
                                             input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
        end
        return 4'b0000;
    endfunction

    function automatic logic [W-1:0] ref_op(input int op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic m_reset();
        m_busy = 0;
        m_age  = 0;
        m_ptr  = 0;
        m_data = '0;
    endtask

    task automatic set_req(input int i, input int op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[2*i +: 2] = 2'(op);
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    // Inputs are driven just after a negedge; check, then advance the model.
    task automatic cyc();
        logic [3:0] exp_ready;
        int g;
        #1;
        exp_ready = m_busy ? 4'b0000 : ref_grant(req_valid, m_ptr);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age == 2));
        if (m_busy && m_age == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
        end
        last_ready = req_ready;
        if (req_ready != 0) begin
            gq.push_back(req_ready);
            tq.push_back(cycle);
        end
        if (!m_busy) begin
            if (exp_ready != 0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
                m_busy = 1;
                m_age  = 1;
                m_id   = g;
                m_res  = ref_op(int'(req_op[2*g +: 2]),
                                req_a[W*g +: W], req_b[W*g +: W]);
                m_ptr  = (g + 1) % 4;
            end
        end else if (m_age == 1) begin
            m_age  = 2;
            m_data = m_res;
        end else if (rsp_ready) begin
            m_busy = 0;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] all_exp [4];
        logic [3:0]   rr_exp [5];
        all_exp = '{8'h30, 8'hFC, 8'hCC, 8'h03};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        m_reset();

        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on requester 0
        set_req(0, 1, 8'hA0, 8'h05);
        req_valid = 4'b0001;
        cyc();
        chk("single_grant", 32'(last_ready), 32'(4'b0001));
        req_valid = '0;
        cyc();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_data", 32'(rsp_data), 32'h A5);
        rsp_ready = 1'b1;
        cyc();

        // Every opcode on requester 2
        for (int op = 0; op < 4; op++) begin
            set_req(2, op, 8'hF0, 8'h3C);
            req_valid = 4'b0100;
            cyc();
            req_valid = '0;
            cyc();
            chk("allops_data", 32'(rsp_data), 32'(all_exp[op]));
            chk("allops_id", 32'(rsp_id), 2);
            cyc();
        end

        // Round robin with all requesters valid
        reset_now();
        gq.delete();
        tq.delete();
        for (int i = 0; i < 4; i++)
            set_req(i, i, 8'(8'h11 * (i + 1)), 8'(8'h0F << i));
        req_valid = 4'b1111;
        repeat (15) cyc();
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));
            if (i > 0) chk("rr_gap", tq[i] - tq[i-1], 3);
        end

        // Backpressure in RESP
        set_req(0, 2, 8'h5A, 8'hFF);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        repeat (5) begin
            chk("bp_ready", 32'(req_ready), 0);
            cyc();
        end
        chk("bp_data", 32'(rsp_data), 32'h A5);
        rsp_ready = 1'b1;
        req_valid = '0;
        cyc();
        chk("bp_done", 32'(rsp_valid), 0);
        cyc();

        // Reset during EXEC of a requester 3 operation
        set_req(3, 0, 8'hFF, 8'h81);
        set_req(1, 1, 8'h01, 8'h02);
        req_valid = 4'b1000;
        cyc();
        req_valid = 4'b1010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_id", 32'(rsp_id), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_grant", 32'(last_ready), 32'(4'b0010));
        req_valid = '0;
        cyc();
        cyc();

        // Pointer wrap from 3 back to 0
        set_req(2, 3, 8'h00, 8'h00);
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        set_req(3, 2, 8'hC3, 8'h0F);
        set_req(0, 0, 8'hC3, 8'h0F);
        req_valid = 4'b1001;
        cyc();
        chk("wrap_first", 32'(last_ready), 32'(4'b1000));
        req_valid = 4'b0001;
        cyc();
        cyc();
        cyc();
        chk("wrap_second", 32'(last_ready), 32'(4'b0001));
        req_valid = '0;
        cyc();
        cyc();

        // Random traffic
        repeat (400) begin
            req_valid = 4'($urandom);
            req_op = 8'($urandom);
            req_a = 32'($urandom);
            req_b = 32'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
